// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, operand_a, operand_b, borrow_in,
    input  busy, done, difference, borrow_out, overflow
  );

  modport slave (
    input  start, operand_a, operand_b, borrow_in,
    output busy, done, difference, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in: one full-subtractor cell, LSB first,
// WIDTH clocks per operation, results held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bit_a, bit_b, bit_d, br_nxt;

  // Full-subtractor cell on the current operand LSBs and the borrow flop.
  always_comb begin
    bit_a  = a_q[0];
    bit_b  = b_q[0];
    bit_d  = bit_a ^ bit_b ^ br_q;
    br_nxt = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);
  end

  // Next-state and datapath update. On the last bit the operand LSBs are
  // the original MSBs (shifted down WIDTH-1 times), so overflow needs no
  // separately captured sign bits.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.operand_a;
          b_d     = bus.operand_b;
          br_d    = bus.borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {bit_d, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_nxt;
        if (cnt_q == LAST) begin
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bo_d    = br_nxt;
          ovf_d   = (bit_a != bit_b) && (bit_d != bit_a);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.difference = diff_q;
  assign bus.borrow_out = bo_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a cycle-level reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: counts edges since acceptance and applies the
  // arithmetic result (plain integer subtraction) at the WIDTH-th edge.
  logic         m_busy = 1'b0, m_done = 1'b0, m_bo = 1'b0, m_ov = 1'b0;
  logic [W-1:0] m_diff = '0;
  int           m_k = 0;
  logic [W:0]   m_pfull = '0;
  logic         m_pov = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_k = 0;
      m_diff = '0; m_bo = 1'b0; m_ov = 1'b0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == W) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_diff = m_pfull[W-1:0];
        m_bo   = m_pfull[W];
        m_ov   = m_pov;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.start) begin
      longint s;
      m_busy  = 1'b1;
      m_k     = 0;
      m_pfull = {1'b0, bus.operand_a} - {1'b0, bus.operand_b} - (W+1)'(bus.borrow_in);
      s = longint'($signed(bus.operand_a)) - longint'($signed(bus.operand_b))
          - longint'(bus.borrow_in);
      m_pov = (s < -(longint'(1) << (W-1))) || (s > (longint'(1) << (W-1)) - 1);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    cyc++;
    if (bus.done === 1'b1) done_cnt++;
    chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
    chk("cyc_done", 32'(bus.done), 32'(m_done));
    chk("cyc_diff", 32'(bus.difference), 32'(m_diff));
    chk("cyc_bout", 32'(bus.borrow_out), 32'(m_bo));
    chk("cyc_ovf", 32'(bus.overflow), 32'(m_ov));
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 4*W) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4*W) chk("idle_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_done(input string nm, output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < W+4) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(W));
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    wait_idle();
    bus.start = 1'b1; bus.operand_a = a; bus.operand_b = b; bus.borrow_in = bin;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.operand_a = ~a; bus.operand_b = ~b; bus.borrow_in = ~bin;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    launch(a, b, bin);
    wait_done(nm, lat);
    chk({nm, "_diff"}, 32'(bus.difference), 32'(ed));
    chk({nm, "_bout"}, 32'(bus.borrow_out), 32'(eb));
    chk({nm, "_ovf"},  32'(bus.overflow),   32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, lat, t1, t2, n;
    bus.start = 1'b0; bus.operand_a = '0; bus.operand_b = '0; bus.borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_diff", 32'(bus.difference), 32'(0));
    rst = 1'b0;

    run_op("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("t2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("t4a", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("t4b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("t4c", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

    // Start during RUN is ignored.
    launch(8'h10, 8'h01, 1'b0);
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1; bus.operand_a = 8'h55; bus.operand_b = 8'h11; bus.borrow_in = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < W+4) begin @(posedge clk); #1; lat++; end
    chk("t5_lat", 32'(lat), 32'(W));
    chk("t5_diff", 32'(bus.difference), 32'(8'h0F));
    repeat (3) @(negedge clk);
    chk("t5_one_done", 32'(done_cnt - d0), 32'(1));
    run_op("t5b", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);

    // Reset mid-RUN after a prior result.
    run_op("t6a", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    launch(8'h20, 8'h01, 1'b0);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(bus.busy), 32'(0));
    chk("t6_done", 32'(bus.done), 32'(0));
    chk("t6_diff", 32'(bus.difference), 32'(0));
    chk("t6_bout", 32'(bus.borrow_out), 32'(0));
    chk("t6_ovf",  32'(bus.overflow), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W+2) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'(0));
    run_op("t6b", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Back-to-back with start held high: one result per W+2 cycles.
    wait_idle();
    bus.start = 1'b1; bus.operand_a = 8'h0A; bus.operand_b = 8'h03; bus.borrow_in = 1'b0;
    d0 = done_cnt; t1 = 0; t2 = 0; n = 0;
    while (done_cnt - d0 < 2 && n < 4*(W+2)) begin
      @(negedge clk); #1;
      n++;
      if (bus.done === 1'b1 && t1 == 0) t1 = cyc;
      else if (bus.done === 1'b1) t2 = cyc;
    end
    bus.start = 1'b0;
    chk("b2b_gap", 32'(t2 - t1), 32'(W+2));
    chk("b2b_diff", 32'(bus.difference), 32'(8'h07));

    repeat (W+4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle bit-serial subtractor for the datapath. It computes operand_a - operand_b - borrow_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart to the combinational full adder. It gives the ALU an area-cheap SUB path with a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2 or more.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
operand_a  input  WIDTH  minuend; captured on the accepted start edge.
operand_b  input  WIDTH  subtrahend; captured on the accepted start edge.
borrow_in  input  1  initial borrow; captured on the accepted start edge.
busy  output  1  high while the bit-serial operation runs.
done  output  1  single-cycle completion pulse.
difference  output  WIDTH  result; updated only on completion.
borrow_out  output  1  final borrow, meaning the unsigned result went below zero.
overflow  output  1  signed two's-complement overflow of a - b.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, difference=0, borrow_out=0, overflow=0.
  - Internal shift registers, borrow flip-flop and bit counter clear to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 captures operand_a, operand_b and borrow_in into internal registers and sets the bit counter to 0.
  - Next state is RUN; busy=1 after E0.
  - start=0 keeps the block in IDLE.
- RUN, at each edge E1..E_WIDTH:
  - Bit a, bit b and borrow br are taken from the current LSBs and the borrow flip-flop.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~a & br) | (b & br).
  - d shifts into the MSB of the internal result register; the operand registers shift right; the counter increments.
  - At edge E_WIDTH (counter = WIDTH-1 before that edge) the block instead does the following:
    - Loads difference with the completed value, including the final bit.
    - Sets borrow_out = br_next.
    - Sets overflow = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
    - Sets done=1 and busy=0, and moves to DONE.
- DONE:
  - done is high for exactly one cycle.
  - At the next edge the state returns to IDLE and done=0.
- Latency: done is visible WIDTH cycles after the accepted start edge. For WIDTH=8, start is sampled at E0 and done is high between E8 and E9.
- Results: difference, borrow_out and overflow hold their values until the next completion. They do not change during RUN.
- start while in RUN or DONE is ignored; there is no queuing. Operand changes after E0 have no effect.
- Back-to-back: start held high continuously gives a new acceptance on the first IDLE edge. The throughput is one result per WIDTH+2 cycles.
- rst asserted mid-RUN:
  - The operation is aborted immediately and all outputs go to their reset values.
  - No done pulse is produced for the aborted operation.
  - After rst deasserts, the block is in IDLE and accepts a new start.
- All arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide and must not wrap before completion.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0 -> done exactly 8 cycles after the start edge; difference=0x02, borrow_out=0, overflow=0; busy high for 8 cycles.
2. a=0x03, b=0x05, bin=0 -> difference=0xFE, borrow_out=1, overflow=0.
3. a=0x80, b=0x01, bin=0 -> difference=0x7F, borrow_out=0, overflow=1.
   - Also a=0x7F, b=0xFF -> difference=0x80, borrow_out=1, overflow=1.
4. a=0x00, b=0x00, bin=1 -> difference=0xFF, borrow_out=1, overflow=0.
   - Also a=0xFF, b=0xFF, bin=1 -> difference=0xFF, borrow_out=1.
5. Start a=0x10, b=0x01, then pulse start with a=0x55, b=0x11 on cycle 3 of RUN -> second start is ignored; difference=0x0F; only one done pulse; a later start in IDLE yields 0x44.
6. Assert rst on cycle 4 of RUN after a prior result of 0x02 -> busy, done, difference, borrow_out and overflow all go to 0 immediately; no done pulse; a new start with a=0x09, b=0x04 gives 0x05 after 8 cycles.
